// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline-register stages.
//   stage_state_e : occupancy state of a pipe_stage_skid instance
//   RV_NOP        : RISC-V canonical NOP (addi x0,x0,0), handy as BUBBLE
//                   for stages whose payload starts with an instruction word
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        ONE   = 2'd1,   // main register live
        FULL  = 2'd2    // main and skid registers live
    } stage_state_e;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- valid/ready pipeline register with a one-entry skid
// buffer. in_ready is a pure function of the registered state, so there is
// no combinational path from out_ready (or flush) to in_ready, yet the stage
// still streams one entry per cycle while the consumer is ready.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-high reset
//   flush      in   synchronous discard of everything held (beats transfers)
//   in_valid   in   upstream offers in_data
//   in_data    in   [WIDTH] upstream payload
//   in_ready   out  stage can take in_data this cycle
//   out_valid  out  out_data is a live entry
//   out_data   out  [WIDTH] head entry, BUBBLE when empty
//   out_ready  in   downstream consumes out_data this cycle
//   occupancy  out  [2] held entries, 0..2
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                WIDTH  = 96,
    parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer, out_xfer;

    // Output decode depends on the registered state only.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state_q)
            ONE:  begin out_valid = 1'b1; occupancy = 2'd1; end
            FULL: begin out_valid = 1'b1; occupancy = 2'd2; in_ready = 1'b0; end
            default: ;
        endcase
    end

    assign out_data = out_valid ? main_q : BUBBLE;
    assign in_xfer  = in_valid  & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;          // pass-through, stay ONE
                    end else if (in_xfer) begin
                        state_d = FULL;            // consumer stalled: park in skid
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (out_xfer) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;          // unreachable encoding recovers
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid -- self-checking bench for pipe_stage_skid. A plain
// queue (max two entries) is the reference: head is the expected out_data,
// its size the expected occupancy.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int               W   = 32;
    localparam logic [W-1:0]     BUB = RV_NOP;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [1:0]   occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] q[$];

    pipe_stage_skid #(.WIDTH(W), .BUBBLE(BUB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the queue semantics to the model.
    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        bit can_in, has_out;
        can_in  = (q.size() < 2);
        has_out = (q.size() > 0);
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (has_out && out_ready) void'(q.pop_front());
            if (in_valid && can_in) q.push_back(in_data);
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] exp_data();
        return (q.size() > 0) ? q[0] : BUB;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== BUB) begin n_err++; $display("FAIL reset_out_data got %h want %h", out_data, BUB); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q.delete();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = W'(k);
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(k)) begin
                n_err++; $display("FAIL stream_%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, k);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0) begin
            n_err++; $display("FAIL stream_drain got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid, out_data, occupancy, BUB);
        end
    endtask

    task automatic fill_full();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_full();
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11) begin
            n_err++; $display("FAIL bp_full got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=11", occupancy, in_ready, out_data);
        end
        // offer while full: must be refused, head must stay put
        in_valid = 1'b1; in_data = 32'h99; tick(); in_valid = 1'b0;
        n_cmp++; if (out_data !== 32'h11 || occupancy !== 2'd2) begin
            n_err++; $display("FAIL bp_hold got d=%h occ=%0d want d=11 occ=2", out_data, occupancy);
        end
        // in_ready must not react combinationally to out_ready
        out_ready = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_path got %b want 0", in_ready); end
        tick();
        n_cmp++; if (out_data !== 32'h22 || occupancy !== 2'd1) begin
            n_err++; $display("FAIL bp_drain1 got d=%h occ=%0d want d=22 occ=1", out_data, occupancy);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== BUB) begin
            n_err++; $display("FAIL bp_drain2 got v=%b occ=%0d d=%h want v=0 occ=0 d=%h", out_valid, occupancy, out_data, BUB);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        fill_full();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0) begin
            n_err++; $display("FAIL flush_empty got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid, out_data, occupancy, BUB);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0 || out_data === 32'h33) begin
                n_err++; $display("FAIL flush_leak_%0d got v=%b d=%h want v=0", i, out_valid, out_data);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        fill_full();
        #2 reset = 1'b1;          // between edges
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset got v=%b d=%h occ=%0d rdy=%b want v=0 d=%h occ=0 rdy=1",
                              out_valid, out_data, occupancy, in_ready, BUB);
        end
        #1 reset = 1'b0;          // released before the next rising edge
        q.delete();
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++; $display("FAIL async_reset_after got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
        // first edge after release must take data
        in_valid = 1'b1; in_data = 32'h5A; tick(); in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h5A) begin
            n_err++; $display("FAIL post_reset_accept got v=%b d=%h want v=1 d=5a", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        int pushed = 0, popped = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            flush     = ($urandom_range(0, 199) == 0);
            if (!flush && in_valid && q.size() < 2) pushed++;
            if (!flush && out_ready && q.size() > 0) popped++;
            tick();
            n_cmp++;
            if (out_valid !== (q.size() > 0) || out_data !== exp_data() ||
                occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2) || occupancy > 2'd2) begin
                n_err++;
                if (bad < 10) $display("FAIL random_c%0d got v=%b d=%h occ=%0d rdy=%b want v=%b d=%h occ=%0d",
                                       c, out_valid, out_data, occupancy, in_ready,
                                       (q.size() > 0), exp_data(), q.size());
                bad++;
            end
        end
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (pushed == 0 || popped == 0) begin
            n_err++; $display("FAIL random_activity got pushed=%0d popped=%0d want both nonzero", pushed, popped);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
